// File: rtl/pipe_ctrl_hazard.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for the 5-stage RV32I core,
// with load-use bubble insertion, taken-branch squash and saturating stall/flush counters.
module pipe_ctrl_hazard #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [7:0]        id_ctrl,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              ex_branch_taken,
   output logic [7:0]        ex_ctrl,
   output logic [REG_AW-1:0] ex_rd,
   output logic [3:0]        mem_ctrl,
   output logic [REG_AW-1:0] mem_rd,
   output logic [1:0]        wb_ctrl,
   output logic [REG_AW-1:0] wb_rd,
   output logic              stall,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   logic hz;
   logic ex_bubble;

   // ex_ctrl[4] is MemRead, ex_ctrl[0] is Branch; x0 never creates a dependency
   assign flush     = ex_ctrl[0] & ex_branch_taken;
   assign hz        = id_valid & ex_ctrl[4] & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   assign stall     = hz & ~flush;
   assign ex_bubble = flush | stall | ~id_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_ctrl     <= '0;
         ex_rd       <= '0;
         mem_ctrl    <= '0;
         mem_rd      <= '0;
         wb_ctrl     <= '0;
         wb_rd       <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (ex_bubble) begin
            ex_ctrl <= '0;
            ex_rd   <= '0;
         end else begin
            ex_ctrl <= id_ctrl;
            ex_rd   <= id_rd;
         end
         mem_ctrl <= ex_ctrl[6:3];
         mem_rd   <= ex_rd;
         wb_ctrl  <= mem_ctrl[3:2];
         wb_rd    <= mem_rd;
         if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
         if (flush && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Scoreboard bench for pipe_ctrl_hazard: a per-instruction pipeline model predicts every cycle,
// a monitor compares; a second instance with 2-bit counters exercises saturation.
module tb_pipe_ctrl_hazard;

   localparam int AW = 5;
   localparam int ALUSRC = 7, MEMTOREG = 6, REGWRITE = 5, MEMREAD = 4, MEMWRITE = 3, BRANCH = 0;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          id_valid = 1'b0;
   logic [7:0]    id_ctrl = '0;
   logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic          ex_branch_taken = 1'b0;

   logic [7:0]    ex_ctrl;
   logic [AW-1:0] ex_rd, mem_rd, wb_rd;
   logic [3:0]    mem_ctrl;
   logic [1:0]    wb_ctrl;
   logic          stall, flush;
   logic [15:0]   stall_count, flush_count;

   logic [7:0]    s_ex_ctrl;
   logic [AW-1:0] s_ex_rd, s_mem_rd, s_wb_rd;
   logic [3:0]    s_mem_ctrl;
   logic [1:0]    s_wb_ctrl;
   logic          s_stall, s_flush;
   logic [1:0]    s_stall_count, s_flush_count;

   always #5 clk = ~clk;

   pipe_ctrl_hazard #(.REG_AW(AW), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
      .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
      .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .stall(stall), .flush(flush),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   pipe_ctrl_hazard #(.REG_AW(AW), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
      .ex_ctrl(s_ex_ctrl), .ex_rd(s_ex_rd), .mem_ctrl(s_mem_ctrl), .mem_rd(s_mem_rd),
      .wb_ctrl(s_wb_ctrl), .wb_rd(s_wb_rd), .stall(s_stall), .flush(s_flush),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   typedef struct {
      logic [7:0]    ctrl;
      logic [AW-1:0] rd;
   } slot_t;

   typedef struct {
      logic          chk_comb;
      logic          e_stall, e_flush;
      logic [7:0]    e_ex_ctrl;
      logic [AW-1:0] e_ex_rd, e_mem_rd, e_wb_rd;
      logic [3:0]    e_mem_ctrl;
      logic [1:0]    e_wb_ctrl;
      int            e_sc, e_fc, e_sc2, e_fc2;
   } exp_t;

   exp_t  sb[$];
   slot_t pipe [3];   // 0 = instruction in EX, 1 = in MEM, 2 = in WB
   int    sc = 0, fc = 0, sc2 = 0, fc2 = 0;
   logic  known = 1'b0;
   int    vectors = 0;
   int    miscompares = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic [7:0] c,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] d, input logic bt);
      exp_t  e;
      slot_t ex;
      slot_t nxt;
      logic  br_taken, load_use, do_stall;
      @(negedge clk);
      reset = rst; id_valid = v; id_ctrl = c;
      id_rs1 = r1; id_rs2 = r2; id_rd = d; ex_branch_taken = bt;

      ex       = pipe[0];
      br_taken = ex.ctrl[BRANCH] && bt;
      load_use = v && ex.ctrl[MEMREAD] && (ex.rd != 0) && (ex.rd == r1 || ex.rd == r2);
      do_stall = load_use && !br_taken;
      e.chk_comb = known;
      e.e_stall  = do_stall;
      e.e_flush  = br_taken;

      if (rst) begin
         for (int i = 0; i < 3; i++) pipe[i] = '{ctrl: 8'h00, rd: '0};
         sc = 0; fc = 0; sc2 = 0; fc2 = 0;
      end else begin
         if (br_taken || do_stall || !v) nxt = '{ctrl: 8'h00, rd: '0};
         else                            nxt = '{ctrl: c, rd: d};
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = nxt;
         if (do_stall) begin
            if (sc < 65535) sc++;
            if (sc2 < 3)    sc2++;
         end
         if (br_taken) begin
            if (fc < 65535) fc++;
            if (fc2 < 3)    fc2++;
         end
      end
      known = 1'b1;

      e.e_ex_ctrl  = pipe[0].ctrl;
      e.e_ex_rd    = pipe[0].rd;
      e.e_mem_ctrl = {pipe[1].ctrl[MEMTOREG], pipe[1].ctrl[REGWRITE],
                      pipe[1].ctrl[MEMREAD], pipe[1].ctrl[MEMWRITE]};
      e.e_mem_rd   = pipe[1].rd;
      e.e_wb_ctrl  = {pipe[2].ctrl[MEMTOREG], pipe[2].ctrl[REGWRITE]};
      e.e_wb_rd    = pipe[2].rd;
      e.e_sc  = sc;  e.e_fc  = fc;
      e.e_sc2 = sc2; e.e_fc2 = fc2;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, '0, '0, '0, 1'b0);
   endtask

   initial begin : monitor
      exp_t cur;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            vectors++;
            if (cur.chk_comb) begin
               check("stall", 32'(stall), 32'(cur.e_stall));
               check("flush", 32'(flush), 32'(cur.e_flush));
               check("sat_stall", 32'(s_stall), 32'(cur.e_stall));
            end
            @(posedge clk);
            #1;
            check("ex_ctrl", 32'(ex_ctrl), 32'(cur.e_ex_ctrl));
            check("ex_rd", 32'(ex_rd), 32'(cur.e_ex_rd));
            check("mem_ctrl", 32'(mem_ctrl), 32'(cur.e_mem_ctrl));
            check("mem_rd", 32'(mem_rd), 32'(cur.e_mem_rd));
            check("wb_ctrl", 32'(wb_ctrl), 32'(cur.e_wb_ctrl));
            check("wb_rd", 32'(wb_rd), 32'(cur.e_wb_rd));
            check("stall_count", 32'(stall_count), 32'(cur.e_sc));
            check("flush_count", 32'(flush_count), 32'(cur.e_fc));
            check("sat_stall_count", 32'(s_stall_count), 32'(cur.e_sc2));
            check("sat_flush_count", 32'(s_flush_count), 32'(cur.e_fc2));
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected end");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [7:0]    rc;
      logic [AW-1:0] rr1, rr2, rrd;
      for (int i = 0; i < 3; i++) pipe[i] = '{ctrl: 8'h00, rd: '0};

      step(1'b1, 1'b0, 8'h00, '0, '0, '0, 1'b0);
      step(1'b1, 1'b0, 8'h00, '0, '0, '0, 1'b0);

      // latency: ALUSrc|RegWrite to x5
      step(1'b0, 1'b1, 8'hA0, 5'd1, 5'd2, 5'd5, 1'b0);
      idle(3);

      // load-use: lw x3 then add using x3 held in ID across the stall
      step(1'b0, 1'b1, 8'hF0, 5'd1, 5'd0, 5'd3, 1'b0);
      step(1'b0, 1'b1, 8'h20, 5'd1, 5'd3, 5'd4, 1'b0);
      step(1'b0, 1'b1, 8'h20, 5'd1, 5'd3, 5'd4, 1'b0);
      idle(3);

      // plain taken branch, then branch with a load-use pending in ID
      step(1'b0, 1'b1, 8'h03, 5'd1, 5'd2, 5'd0, 1'b0);
      step(1'b0, 1'b1, 8'h20, 5'd1, 5'd2, 5'd7, 1'b1);
      step(1'b0, 1'b1, 8'h13, 5'd1, 5'd2, 5'd6, 1'b0);
      step(1'b0, 1'b1, 8'h20, 5'd6, 5'd2, 5'd7, 1'b1);
      idle(3);

      // x0 destination never stalls; invalid ID becomes a bubble
      step(1'b0, 1'b1, 8'hF0, 5'd1, 5'd2, 5'd0, 1'b0);
      step(1'b0, 1'b1, 8'h20, 5'd0, 5'd0, 5'd8, 1'b0);
      step(1'b0, 1'b0, 8'hFF, 5'd1, 5'd2, 5'd9, 1'b0);
      idle(3);

      // five stalls back to back drive the 2-bit counters into saturation
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 8'hF0, 5'd1, 5'd2, 5'd3, 1'b0);
         step(1'b0, 1'b1, 8'h20, 5'd3, 5'd2, 5'd4, 1'b0);
      end
      idle(3);

      // reset held two cycles with instructions in flight
      step(1'b0, 1'b1, 8'hF8, 5'd1, 5'd2, 5'd7, 1'b0);
      step(1'b0, 1'b1, 8'hA0, 5'd1, 5'd2, 5'd9, 1'b0);
      step(1'b1, 1'b1, 8'hA0, 5'd1, 5'd2, 5'd10, 1'b0);
      step(1'b1, 1'b1, 8'hA0, 5'd1, 5'd2, 5'd11, 1'b0);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         rc  = 8'($urandom);
         rr1 = AW'($urandom_range(0, 3));
         rr2 = AW'($urandom_range(0, 3));
         rrd = AW'($urandom_range(0, 3));
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), rc, rr1, rr2, rrd,
              1'($urandom));
      end

      @(negedge clk);
      @(negedge clk);
      #5;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
